light_ctrl_p: RTL and testbench
===============================

LIGHT_CTRL_P -- requirements
Module: light_ctrl_p

Interface
REQ-001 Parameter CH_N, default 2, number of filling channels with a full sensor; legal range 2..8.
REQ-002 Parameter LIGHT_W, default 4, width of each light code output; legal range >= 4.
REQ-003 Parameter BLINK_DIV, default 1000, clock cycles per blink half-period; legal range >= 2.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 EN_work  input  1  work-state enable.
REQ-007 EN_set  input  1  set-state enable.
REQ-008 SET  input  1  set selector.
REQ-009 full  input  CH_N  per-channel full flag, level, synchronous to CLK.
REQ-010 ALM_ACK  input  1  operator alarm acknowledge, level.
REQ-011 light  output  LIGHT_W  operating-mode code, registered.
REQ-012 light2  output  LIGHT_W  machine-status code, registered.
REQ-013 full_ch  output  CH_N  latched per-channel full alarm.
REQ-014 alm_idx  output  $clog2(CH_N)  index of the lowest set full_ch bit; 0 when none is set.
REQ-015 blink  output  1  blink phase; 1 = lamp on.

Function
REQ-016 The mode decode shall be registered: inputs sampled at edge k appear on light/light2 after edge k (1-cycle latency).
REQ-017 Mode codes (light, light2), upper bits above bit 3 zero: EN_work=1,EN_set=1 -> (0,1) fault; EN_work=0,EN_set=0,SET=0 -> (1,4); EN_work=0,EN_set=0,SET=1 -> (2,4); EN_work=0,EN_set=1 -> (3,8); EN_work=1,EN_set=0,SET=0 -> (4,2); EN_work=1,EN_set=0,SET=1 -> (5,2).
REQ-018 full_ch[i] shall set on any edge where full[i]=1.
REQ-019 full_ch[i] shall clear only on an edge where ALM_ACK=1 and full[i]=0; bits with full[i]=1 stay set (set wins over acknowledge).
REQ-020 Alarm active = OR of full_ch after the edge; a cycle in which full_ch goes 0 -> nonzero is alarm entry.
REQ-021 Blink counter shall run 0..BLINK_DIV-1 while the alarm is active, wrapping to 0 and toggling blink at terminal count BLINK_DIV-1.
REQ-022 On alarm entry, the counter shall load 0 and blink shall load 1, so the first on-phase lasts exactly BLINK_DIV cycles.
REQ-023 While no alarm is active, the counter shall hold 0 and blink shall hold 0.
REQ-024 While the alarm is active, light2 shall be 1 when blink=1 and 0 when blink=0, overriding REQ-017 status; light follows REQ-017 unchanged.
REQ-025 In the fault mode (EN_work=EN_set=1) with no alarm, light2 shall be steady 1.
REQ-026 alm_idx shall be registered together with full_ch and reflect the same edge's full_ch value.
REQ-027 Mode changes during an active alarm shall not restart the blink counter.
REQ-028 On alarm clear (full_ch -> 0), blink and the counter shall return to 0 on the same edge, and light2 shall show the REQ-017 status.

Reset
REQ-029 RST_N=0 shall asynchronously force light=0, light2=0, full_ch=0, alm_idx=0, blink=0, counter=0, independent of CLK.
REQ-030 Reset asserted mid-alarm shall discard all latched alarms; after release, the first edge follows REQ-016..REQ-019 from the sampled inputs.

Verification (CH_N=2, BLINK_DIV=4)
REQ-031 Reset release, then EN_work=0, EN_set=0, SET=1 -> after 1 edge light=2, light2=4; then EN_work=1, SET=0 -> light=4, light2=2.
REQ-032 full=2'b10 for 1 cycle in work mode -> full_ch=10, alm_idx=1, blink=1; light2 sequence 1,1,1,1,0,0,0,0,1... with light=4 steady.
REQ-033 full=2'b11 held, ALM_ACK=1 -> full_ch stays 11; drop full[0] with ACK held -> full_ch=10, alm_idx=1; drop full[1] -> full_ch=00, blink=0, light2=2.
REQ-034 EN_work=EN_set=1 with no alarm -> light=0, light2=1 steady for 20 cycles, blink=0.
REQ-035 Alarm active, toggle EN_set mid half-period -> light changes to the new code while blink period stays 4 cycles unbroken.
REQ-036 Assert RST_N=0 between edges during an alarm -> all outputs 0 immediately; release with full=00 -> full_ch remains 00.

Source files
------------

// File: rtl/light_ctrl_p.sv
// Filling-line lamp controller: registered mode/status lamp codes plus a latched
// per-channel full alarm that blinks the status lamp until acknowledged.
module light_ctrl_p #(
  parameter int unsigned CH_N      = 2,
  parameter int unsigned LIGHT_W   = 4,
  parameter int unsigned BLINK_DIV = 1000
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    EN_work,
  input  logic                    EN_set,
  input  logic                    SET,
  input  logic [CH_N-1:0]         full,
  input  logic                    ALM_ACK,
  output logic [LIGHT_W-1:0]      light,
  output logic [LIGHT_W-1:0]      light2,
  output logic [CH_N-1:0]         full_ch,
  output logic [$clog2(CH_N)-1:0] alm_idx,
  output logic                    blink
);

  localparam int unsigned IdxW = $clog2(CH_N);
  localparam int unsigned CntW = $clog2(BLINK_DIV);

  // Enumerator values equal the operating-mode lamp code.
  typedef enum logic [2:0] {
    ModeFault   = 3'd0,
    ModeIdle    = 3'd1,
    ModeIdleSet = 3'd2,
    ModeSetup   = 3'd3,
    ModeWork    = 3'd4,
    ModeWorkSet = 3'd5
  } mode_e;

  mode_e               mode_d;
  logic [CH_N-1:0]     full_ch_d, full_ch_q;
  logic [IdxW-1:0]     idx_d, idx_q;
  logic [CntW-1:0]     cnt_d, cnt_q;
  logic                blink_d, blink_q;
  logic                alarm_d;
  logic                alarm_entry;
  logic [LIGHT_W-1:0]  light_d, light_q;
  logic [LIGHT_W-1:0]  light2_d, light2_q;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      full_ch_q <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      blink_q   <= 1'b0;
      light_q   <= '0;
      light2_q  <= '0;
    end else begin
      full_ch_q <= full_ch_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      blink_q   <= blink_d;
      light_q   <= light_d;
      light2_q  <= light2_d;
    end
  end

  // Next-state: alarm latch, priority index and blink timer
  always_comb begin
    // A raised full flag always wins over the acknowledge.
    full_ch_d   = full | (ALM_ACK ? '0 : full_ch_q);
    alarm_d     = |full_ch_d;
    alarm_entry = alarm_d & ~(|full_ch_q);

    idx_d = '0;
    for (int i = int'(CH_N) - 1; i >= 0; i--) begin
      if (full_ch_d[i]) begin
        idx_d = IdxW'(i);
      end
    end

    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (!alarm_d) begin
      cnt_d   = '0;
      blink_d = 1'b0;
    end else if (alarm_entry) begin
      cnt_d   = '0;
      blink_d = 1'b1;
    end else if (cnt_q == CntW'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      blink_d = ~blink_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Output decode, registered by the state register above
  always_comb begin
    mode_d = ModeFault;
    if (EN_work && EN_set) begin
      mode_d = ModeFault;
    end else if (EN_set) begin
      mode_d = ModeSetup;
    end else if (EN_work) begin
      mode_d = SET ? ModeWorkSet : ModeWork;
    end else begin
      mode_d = SET ? ModeIdleSet : ModeIdle;
    end

    light_d = LIGHT_W'(mode_d);

    unique case (mode_d)
      ModeFault:             light2_d = LIGHT_W'(1);
      ModeIdle, ModeIdleSet: light2_d = LIGHT_W'(4);
      ModeSetup:             light2_d = LIGHT_W'(8);
      ModeWork, ModeWorkSet: light2_d = LIGHT_W'(2);
      default:               light2_d = LIGHT_W'(1);
    endcase

    if (alarm_d) begin
      light2_d = blink_d ? LIGHT_W'(1) : '0;
    end
  end

  assign light   = light_q;
  assign light2  = light2_q;
  assign full_ch = full_ch_q;
  assign alm_idx = idx_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_light_ctrl_p.sv
// Directed bench for light_ctrl_p with CH_N=2, BLINK_DIV=4: a vector table for the
// single-edge behaviour plus hand sequences for blink timing, ack and reset.
module tb_light_ctrl_p;

  logic       CLK;
  logic       RST_N;
  logic       EN_work;
  logic       EN_set;
  logic       SET;
  logic [1:0] full;
  logic       ALM_ACK;
  logic [3:0] light;
  logic [3:0] light2;
  logic [1:0] full_ch;
  logic [0:0] alm_idx;
  logic       blink;

  int n_checks = 0;
  int n_pass   = 0;

  light_ctrl_p #(
    .CH_N      (2),
    .LIGHT_W   (4),
    .BLINK_DIV (4)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .EN_work (EN_work),
    .EN_set  (EN_set),
    .SET     (SET),
    .full    (full),
    .ALM_ACK (ALM_ACK),
    .light   (light),
    .light2  (light2),
    .full_ch (full_ch),
    .alm_idx (alm_idx),
    .blink   (blink)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       w;
    logic       s;
    logic       set;
    logic [1:0] f;
    logic       ack;
    int         l;
    int         l2;
    int         fc;
    int         idx;
    int         bl;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input int l, input int l2, input int fc,
                         input int idx, input int bl);
    chk({tag, ".light"},   int'(light),   l);
    chk({tag, ".light2"},  int'(light2),  l2);
    chk({tag, ".full_ch"}, int'(full_ch), fc);
    chk({tag, ".alm_idx"}, int'(alm_idx), idx);
    chk({tag, ".blink"},   int'(blink),   bl);
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic w, input logic s, input logic st, input logic [1:0] f,
                       input logic ack);
    EN_work = w;
    EN_set  = s;
    SET     = st;
    full    = f;
    ALM_ACK = ack;
  endtask

  initial begin
    //            w     s     set   full   ack   l  l2 fc idx bl
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1, 4, 0, 0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2, 4, 0, 0, 0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4, 2, 0, 0, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3, 8, 0, 0, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 3, 8, 0, 0, 0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 5, 2, 0, 0, 0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 0, 1, 0, 0, 0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4, 1, 1, 0, 1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4, 1, 1, 0, 1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 4, 1, 3, 0, 1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4, 2, 0, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 4, 1, 2, 1, 1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4, 2, 0, 0, 0};

    RST_N = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    #12;
    chk_all("reset", 0, 0, 0, 0, 0);

    step();
    RST_N = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].w, vecs[i].s, vecs[i].set, vecs[i].f, vecs[i].ack);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].l, vecs[i].l2, vecs[i].fc, vecs[i].idx,
              vecs[i].bl);
    end

    // Single-cycle full pulse, then a mode toggle mid half-period: 4-cycle phases hold.
    drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    for (int n = 1; n <= 17; n++) begin
      step();
      chk_all($sformatf("blink%0d", n), (n >= 11 && n < 14) ? 0 : 4,
              (((n - 1) / 4) % 2 == 0) ? 1 : 0, 2, 1, (((n - 1) / 4) % 2 == 0) ? 1 : 0);
      full = 2'b00;
      if (n == 10) EN_set = 1'b1;
      if (n == 13) EN_set = 1'b0;
    end

    // Asynchronous reset between edges while the alarm is latched.
    #3;
    RST_N = 1'b0;
    #1;
    chk_all("midrst", 0, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    #2;
    RST_N = 1'b1;
    step();
    chk_all("postrst", 4, 2, 0, 0, 0);

    // Acknowledge held while flags are still up, then dropped one by one.
    drive(1'b1, 1'b0, 1'b0, 2'b11, 1'b1);
    step();
    chk_all("ack0", 4, 1, 3, 0, 1);
    step();
    chk_all("ack1", 4, 1, 3, 0, 1);
    full = 2'b10;
    step();
    chk_all("ack2", 4, 1, 2, 1, 1);
    full = 2'b00;
    step();
    chk_all("ack3", 4, 2, 0, 0, 0);

    // Fault mode without alarm: steady status lamp.
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    for (int n = 0; n < 20; n++) begin
      step();
      chk_all($sformatf("fault%0d", n), 0, 1, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
